// File: rtl/cw305_usb_bus_master_if.sv
// cw305_usb_bus_master_if: command, write/read stream and parallel register bus signals of the bus master
interface cw305_usb_bus_master_if #(
    parameter int pADDR_WIDTH   = 21,
    parameter int pBYTECNT_SIZE = 7
) ();
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic                     cmd_write;
    logic [pADDR_WIDTH-1:0]   cmd_addr;
    logic [pBYTECNT_SIZE-1:0] cmd_len;
    logic [7:0]               wr_data;
    logic                     wr_valid;
    logic                     wr_ready;
    logic [7:0]               rd_data;
    logic                     rd_valid;
    logic                     done;
    logic [pADDR_WIDTH-1:0]   usb_addr;
    logic [7:0]               usb_dout;
    logic                     usb_dout_oe;
    logic [7:0]               usb_din;
    logic                     usb_cen;
    logic                     usb_rdn;
    logic                     usb_wrn;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid, usb_din,
        output cmd_ready, wr_ready, rd_data, rd_valid, done,
        output usb_addr, usb_dout, usb_dout_oe, usb_cen, usb_rdn, usb_wrn
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid, usb_din,
        input  cmd_ready, wr_ready, rd_data, rd_valid, done,
        input  usb_addr, usb_dout, usb_dout_oe, usb_cen, usb_rdn, usb_wrn
    );
endinterface

// File: rtl/cw305_usb_bus_master.sv
// cw305_usb_bus_master: byte-wise read/write bursts on the CW305 parallel register bus with programmable strobe timing
module cw305_usb_bus_master #(
    parameter int pADDR_WIDTH   = 21,
    parameter int pBYTECNT_SIZE = 7,
    parameter int pSETUP        = 1,
    parameter int pSTROBE       = 2,
    parameter int pHOLD         = 1
) (
    input logic                     usb_clk,
    input logic                     resetn,
    cw305_usb_bus_master_if.master  bus
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] WDATA  = 3'd1;
    localparam logic [2:0] SETUP  = 3'd2;
    localparam logic [2:0] STROBE = 3'd3;
    localparam logic [2:0] HOLD   = 3'd4;
    localparam logic [7:0] SETUP_LAST  = 8'(pSETUP - 1);
    localparam logic [7:0] STROBE_LAST = 8'(pSTROBE - 1);
    localparam logic [7:0] HOLD_LAST   = 8'(pHOLD - 1);

    logic [2:0]               state_q, state_d;
    logic [7:0]               cnt_q, cnt_d;
    logic                     write_q, write_d;
    logic [pADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [pBYTECNT_SIZE-1:0] len_q, len_d;
    logic [pBYTECNT_SIZE-1:0] idx_q, idx_d;
    logic [pBYTECNT_SIZE-1:0] low_d;
    logic                     cmd_ready_q, cmd_ready_d;
    logic                     wr_ready_q, wr_ready_d;
    logic [7:0]               rd_data_q, rd_data_d;
    logic                     rd_valid_q, rd_valid_d;
    logic                     done_q, done_d;
    logic [pADDR_WIDTH-1:0]   usb_addr_q, usb_addr_d;
    logic [7:0]               usb_dout_q, usb_dout_d;
    logic                     usb_dout_oe_q, usb_dout_oe_d;
    logic                     usb_cen_q, usb_cen_d;
    logic                     usb_rdn_q, usb_rdn_d;
    logic                     usb_wrn_q, usb_wrn_d;
    logic                     last, more, cmd_fire, wr_fire, rd_sample;

    assign last      = cnt_q == (state_q == SETUP ? SETUP_LAST : state_q == STROBE ? STROBE_LAST : HOLD_LAST);
    assign more      = idx_q != len_q;
    assign cmd_fire  = bus.cmd_valid && cmd_ready_q;
    assign wr_fire   = bus.wr_valid && wr_ready_q;
    assign rd_sample = state_q == STROBE && last && !write_q;

    // Sequencing: command latch, per-phase cycle counter and byte index
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        len_d   = len_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: if (cmd_fire) begin
                write_d = bus.cmd_write;
                addr_d  = bus.cmd_addr;
                len_d   = bus.cmd_len;
                idx_d   = '0;
                cnt_d   = '0;
                state_d = bus.cmd_write ? WDATA : SETUP;
            end
            WDATA: if (wr_fire) begin
                cnt_d   = '0;
                state_d = SETUP;
            end
            SETUP, STROBE, HOLD: begin
                cnt_d = last ? 8'd0 : cnt_q + 8'd1;
                if (last && state_q == SETUP)
                    state_d = STROBE;
                else if (last && state_q == STROBE)
                    state_d = HOLD;
                else if (last && more) begin
                    idx_d   = idx_q + 1'b1;
                    state_d = write_q ? WDATA : SETUP;
                end else if (last)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs are derived from the state being entered so they line up with it
    always_comb begin
        low_d         = addr_d[pBYTECNT_SIZE-1:0] + idx_d;
        cmd_ready_d   = state_d == IDLE;
        wr_ready_d    = state_d == WDATA;
        usb_cen_d     = state_d == IDLE ? 1'b1 : state_d == SETUP ? 1'b0 : usb_cen_q;
        usb_dout_oe_d = state_d == IDLE ? 1'b0 : state_d == SETUP ? write_d : usb_dout_oe_q;
        usb_addr_d    = state_d == SETUP ? {addr_d[pADDR_WIDTH-1:pBYTECNT_SIZE], low_d} : usb_addr_q;
        usb_dout_d    = state_q == WDATA && wr_fire ? bus.wr_data : usb_dout_q;
        usb_rdn_d     = !(state_d == STROBE && !write_d);
        usb_wrn_d     = !(state_d == STROBE && write_d);
        rd_data_d     = rd_sample ? bus.usb_din : rd_data_q;
        rd_valid_d    = rd_sample;
        done_d        = state_q == HOLD && last && !more;
    end

    // State and output registers; reset parks the bus idle immediately
    always_ff @(posedge usb_clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            write_q       <= 1'b0;
            addr_q        <= '0;
            len_q         <= '0;
            idx_q         <= '0;
            cmd_ready_q   <= 1'b1;
            wr_ready_q    <= 1'b0;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
            done_q        <= 1'b0;
            usb_addr_q    <= '0;
            usb_dout_q    <= '0;
            usb_dout_oe_q <= 1'b0;
            usb_cen_q     <= 1'b1;
            usb_rdn_q     <= 1'b1;
            usb_wrn_q     <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            write_q       <= write_d;
            addr_q        <= addr_d;
            len_q         <= len_d;
            idx_q         <= idx_d;
            cmd_ready_q   <= cmd_ready_d;
            wr_ready_q    <= wr_ready_d;
            rd_data_q     <= rd_data_d;
            rd_valid_q    <= rd_valid_d;
            done_q        <= done_d;
            usb_addr_q    <= usb_addr_d;
            usb_dout_q    <= usb_dout_d;
            usb_dout_oe_q <= usb_dout_oe_d;
            usb_cen_q     <= usb_cen_d;
            usb_rdn_q     <= usb_rdn_d;
            usb_wrn_q     <= usb_wrn_d;
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.wr_ready    = wr_ready_q;
    assign bus.rd_data     = rd_data_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.done        = done_q;
    assign bus.usb_addr    = usb_addr_q;
    assign bus.usb_dout    = usb_dout_q;
    assign bus.usb_dout_oe = usb_dout_oe_q;
    assign bus.usb_cen     = usb_cen_q;
    assign bus.usb_rdn     = usb_rdn_q;
    assign bus.usb_wrn     = usb_wrn_q;
endmodule
